// File: rtl/cc_opt_pkg.sv
// Shared constants and types for the CC_OPT_DELAY multi-channel handler.
package cc_opt_pkg;

  localparam logic [4:0] CC_OPT_DELAY = 5'd10;

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_LATCH     = 4'd1;
  localparam logic [3:0] ST_START_OPT = 4'd2;
  localparam logic [3:0] ST_WAIT_OPT  = 4'd3;
  localparam logic [3:0] ST_NEXT_CHAN = 4'd4;
  localparam logic [3:0] ST_ECHO_CSN  = 4'd5;
  localparam logic [3:0] ST_ECHO_CC   = 4'd6;
  localparam logic [3:0] ST_XMIT_DATA = 4'd7;
  localparam logic [3:0] ST_DONE      = 4'd8;

  typedef enum logic [3:0] {
    S_IDLE      = ST_IDLE,
    S_LATCH     = ST_LATCH,
    S_START_OPT = ST_START_OPT,
    S_WAIT_OPT  = ST_WAIT_OPT,
    S_NEXT_CHAN = ST_NEXT_CHAN,
    S_ECHO_CSN  = ST_ECHO_CSN,
    S_ECHO_CC   = ST_ECHO_CC,
    S_XMIT_DATA = ST_XMIT_DATA,
    S_DONE      = ST_DONE
  } cc_opt_state_e;

  localparam int CHAN_FIELD_LSB = 8;
  localparam int TMO_FIELD_LSB  = 16;

endpackage

// File: rtl/cc_opt_timeout_ctr.sv
// Per-channel optimizer timeout counter; only built when CC_OPT_TIMEOUT_EN is defined.
`ifdef CC_OPT_TIMEOUT_EN
module cc_opt_timeout_ctr #(
  parameter int W = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [W-1:0] ALL_ONES = '1;
  // tc is raised during the (2^W - 1)-th enabled cycle after a clear
  localparam logic [W-1:0] TC_VAL   = ALL_ONES - W'(1);

  logic [W-1:0] cnt_q, cnt_d;

  // next count: clear wins, then saturating increment
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != TC_VAL)) begin
      cnt_d = cnt_q + W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // count register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = en_i && (cnt_q == TC_VAL);

endmodule
`endif

// File: rtl/cc_opt_delay_multi_sm.sv
// CC_OPT_DELAY handler: optimizes each masked channel in turn, then streams CSN, CC and results.
// Optional per-channel timeout enabled by defining CC_OPT_TIMEOUT_EN.
module cc_opt_delay_multi_sm
  import cc_opt_pkg::*;
#(
  parameter int NUM_CHAN  = 4,
  parameter int DELAY_W   = 5,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT_W = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    run_sm,
  input  logic [NUM_CHAN-1:0]     chan_mask,
  output logic                    sm_running,
  output logic                    sm_done,
  output logic                    tx_tvalid,
  output logic                    tx_tlast,
  input  logic                    tx_tready,
  output logic                    send_csn,
  output logic                    send_cmd,
  output logic                    send_inv_cmd,
  output logic                    send_data,
  output logic [DATA_W-1:0]       tx_data,
  output logic [((NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1)-1:0] opt_chan,
  output logic                    start_opt,
  input  logic                    opt_done,
  input  logic                    opt_fail,
  input  logic [DELAY_W-1:0]      opt_delay
);

  localparam int CHW = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;

  cc_opt_state_e       state_q, state_d;
  logic [NUM_CHAN-1:0] mask_q, mask_d;
  logic [NUM_CHAN-1:0] fail_q, fail_d;
  logic [NUM_CHAN-1:0] tmo_q, tmo_d;
  logic [CHW-1:0]      chan_q, chan_d;
  logic [DELAY_W-1:0]  result_q [NUM_CHAN];
  logic [DELAY_W-1:0]  result_d [NUM_CHAN];
  logic                err_q, err_d;
  logic [CHW:0]        latch_first_s, first_s, next_s;
  logic                tmo_tc_s;

  // {found, index} of the lowest set bit of m at or above position from
  function automatic logic [CHW:0] next_bit(input logic [NUM_CHAN-1:0] m, input int from);
    logic [CHW:0] r;
    r = '0;
    for (int i = NUM_CHAN - 1; i >= 0; i--) begin
      if (m[i] && (i >= from)) begin
        r = {1'b1, CHW'(i)};
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  assign latch_first_s = next_bit(chan_mask, 0);
  assign first_s       = next_bit(mask_q, 0);
  assign next_s        = next_bit(mask_q, int'(chan_q) + 1);

`ifdef CC_OPT_TIMEOUT_EN
  cc_opt_timeout_ctr #(.W(TIMEOUT_W)) u_tmo_ctr (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .clr_i  (state_q == S_START_OPT),
    .en_i   (state_q == S_WAIT_OPT),
    .tc_o   (tmo_tc_s)
  );
`else
  // no counter: WAIT_OPT only leaves on opt_done
  assign tmo_tc_s = (TIMEOUT_W < 1);
`endif

  // next-state and register updates
  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    fail_d   = fail_q;
    tmo_d    = tmo_q;
    chan_d   = chan_q;
    result_d = result_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        fail_d = '0;
        tmo_d  = '0;
        err_d  = 1'b0;
        for (int i = 0; i < NUM_CHAN; i++) result_d[i] = '0;
        state_d = run_sm ? S_LATCH : S_IDLE;
      end
      S_LATCH: begin
        mask_d = chan_mask;
        if (!latch_first_s[CHW]) begin
          err_d   = 1'b1;
          state_d = S_ECHO_CSN;
        end else begin
          chan_d  = latch_first_s[CHW-1:0];
          state_d = S_START_OPT;
        end
      end
      S_START_OPT: state_d = S_WAIT_OPT;
      S_WAIT_OPT: begin
        // opt_done takes priority over a coincident timeout
        if (opt_done) begin
          result_d[chan_q] = opt_delay;
          if (opt_fail) fail_d[chan_q] = 1'b1;
          else          fail_d[chan_q] = fail_q[chan_q];
          state_d = S_NEXT_CHAN;
        end else if (tmo_tc_s) begin
          fail_d[chan_q] = 1'b1;
          tmo_d[chan_q]  = 1'b1;
          state_d = S_NEXT_CHAN;
        end else begin
          state_d = S_WAIT_OPT;
        end
      end
      S_NEXT_CHAN: begin
        err_d = (mask_q == '0) | (|fail_q);
        if (next_s[CHW]) begin
          chan_d  = next_s[CHW-1:0];
          state_d = S_START_OPT;
        end else begin
          state_d = S_ECHO_CSN;
        end
      end
      S_ECHO_CSN: state_d = tx_tready ? S_ECHO_CC : S_ECHO_CSN;
      S_ECHO_CC: begin
        if (tx_tready) begin
          // the data phase walks the mask again from its lowest channel
          if (!err_q && first_s[CHW]) chan_d = first_s[CHW-1:0];
          else                        chan_d = chan_q;
          state_d = S_XMIT_DATA;
        end else begin
          state_d = S_ECHO_CC;
        end
      end
      S_XMIT_DATA: begin
        if (tx_tready) begin
          if (err_q || !next_s[CHW]) begin
            state_d = S_DONE;
          end else begin
            chan_d  = next_s[CHW-1:0];
            state_d = S_XMIT_DATA;
          end
        end else begin
          state_d = S_XMIT_DATA;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (!run_sm) state_d = S_IDLE;
    else         state_d = state_d;
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      mask_q  <= '0;
      fail_q  <= '0;
      tmo_q   <= '0;
      chan_q  <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < NUM_CHAN; i++) result_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      fail_q   <= fail_d;
      tmo_q    <= tmo_d;
      chan_q   <= chan_d;
      err_q    <= err_d;
      result_q <= result_d;
    end
  end

  // Moore outputs; start_opt and tvalid also gated by run_sm so an abort drops them at once
  always_comb begin
    sm_done      = 1'b0;
    tx_tvalid    = 1'b0;
    tx_tlast     = 1'b0;
    send_csn     = 1'b0;
    send_cmd     = 1'b0;
    send_inv_cmd = 1'b0;
    send_data    = 1'b0;
    tx_data      = '0;
    start_opt    = 1'b0;
    sm_running   = (state_q != S_IDLE);
    case (state_q)
      S_START_OPT: start_opt = run_sm;
      S_ECHO_CSN: begin
        send_csn  = 1'b1;
        tx_tvalid = run_sm;
      end
      S_ECHO_CC: begin
        send_cmd     = !err_q;
        send_inv_cmd = err_q;
        tx_tvalid    = run_sm;
      end
      S_XMIT_DATA: begin
        send_data = 1'b1;
        tx_tvalid = run_sm;
        tx_tlast  = err_q | !next_s[CHW];
        if (err_q) begin
          tx_data[NUM_CHAN-1:0]               = fail_q;
          tx_data[TMO_FIELD_LSB +: NUM_CHAN]  = tmo_q;
        end else begin
          tx_data[DELAY_W-1:0]                = result_q[chan_q];
          tx_data[CHAN_FIELD_LSB +: 8]        = 8'(chan_q);
        end
      end
      S_DONE:  sm_done = 1'b1;
      default: sm_done = 1'b0;
    endcase
  end

  assign opt_chan = chan_q;

endmodule

// File: tb/tb_cc_opt_delay_multi_sm.sv
// Scoreboard bench for cc_opt_delay_multi_sm with a behavioural optimizer and TX sink.
module tb_cc_opt_delay_multi_sm;

  localparam int NUM_CHAN  = 4;
  localparam int DELAY_W   = 5;
  localparam int DATA_W    = 32;
  localparam int TIMEOUT_W = 4;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic                run_sm = 1'b0;
  logic [NUM_CHAN-1:0] chan_mask = '0;
  logic                sm_running, sm_done, tx_tvalid, tx_tlast;
  logic                tx_tready = 1'b0;
  logic                send_csn, send_cmd, send_inv_cmd, send_data;
  logic [DATA_W-1:0]   tx_data;
  logic [1:0]          opt_chan;
  logic                start_opt;
  logic                opt_done = 1'b0;
  logic                opt_fail = 1'b0;
  logic [DELAY_W-1:0]  opt_delay = '0;

  always #5 clk = ~clk;

  cc_opt_delay_multi_sm #(
    .NUM_CHAN(NUM_CHAN), .DELAY_W(DELAY_W), .DATA_W(DATA_W), .TIMEOUT_W(TIMEOUT_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .run_sm(run_sm), .chan_mask(chan_mask),
    .sm_running(sm_running), .sm_done(sm_done), .tx_tvalid(tx_tvalid), .tx_tlast(tx_tlast),
    .tx_tready(tx_tready), .send_csn(send_csn), .send_cmd(send_cmd),
    .send_inv_cmd(send_inv_cmd), .send_data(send_data), .tx_data(tx_data),
    .opt_chan(opt_chan), .start_opt(start_opt), .opt_done(opt_done),
    .opt_fail(opt_fail), .opt_delay(opt_delay)
  );

  int checks = 0;
  int errors = 0;

  logic [DELAY_W-1:0]  delays [NUM_CHAN];
  logic [NUM_CHAN-1:0] fail_vec;
  logic [39:0]         exp_q [$];
  int                  chan_exp [$];
  int cd, lat, never_done, tr_mode, cyc, n_start, n_done, last_start, first_valid, tcnt;
  logic                prev_stall;
  logic [39:0]         prev_obs;
  logic [3:0]          tr_pat = 4'b1001;

  function automatic logic [39:0] mkword(input logic csn, input logic cmd, input logic inv,
                                         input logic sd, input logic last, input logic [31:0] d);
    return {3'b000, csn, cmd, inv, sd, last, d};
  endfunction

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // one clock: optimizer model, tready drive, scoreboard and hold checks at the negedge
  task automatic step();
    logic [39:0] obs;
    logic [39:0] ex;
    @(negedge clk);
    cyc++;
    opt_done = 1'b0; opt_fail = 1'b0; opt_delay = '0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        opt_done  = 1'b1;
        opt_fail  = fail_vec[opt_chan];
        opt_delay = delays[opt_chan];
      end
    end
    if (start_opt) begin
      n_start++;
      last_start = cyc;
      chk("opt_chan", 40'(opt_chan), (chan_exp.size() > 0) ? 40'(chan_exp.pop_front()) : 40'hFF);
      cd = (never_done != 0) ? 0 : lat;
    end
    if (tr_mode == 0)      tx_tready = 1'b1;
    else if (tr_mode == 1) tx_tready = tr_pat[tcnt % 4];
    else                   tx_tready = 1'b0;
    if (tx_tvalid) begin
      if (tr_mode == 1) tcnt++;
      if (first_valid < 0) first_valid = cyc;
      obs = mkword(send_csn, send_cmd, send_inv_cmd, send_data, tx_tlast,
                   send_data ? tx_data[31:0] : 32'h0);
      if (prev_stall) chk("hold_word", obs, prev_obs);
      if (tx_tready) begin
        ex = (exp_q.size() > 0) ? exp_q.pop_front() : 40'hFF_FFFF_FFFF;
        chk("word", obs, ex);
        prev_stall = 1'b0;
      end else begin
        prev_stall = 1'b1;
        prev_obs   = obs;
      end
    end else if (prev_stall) begin
      chk("hold_valid", 40'(tx_tvalid), 40'd1);
      prev_stall = 1'b0;
    end
    if (sm_done) n_done++;
  endtask

  task automatic run_case(input string name, input logic [3:0] mask, input int l,
                          input int trm, input int nd);
    logic [3:0] fm, tm;
    logic       err;
    int         hi, nexp;
    bit         done;
    lat = l; tr_mode = trm; never_done = nd; cd = 0;
    n_start = 0; n_done = 0; first_valid = -1; last_start = -1; tcnt = 0; prev_stall = 1'b0;
    exp_q.delete(); chan_exp.delete();
    tm  = (nd != 0) ? mask : 4'b0000;
    fm  = (mask & fail_vec) | tm;
    err = (mask == 4'b0000) | (|fm);
    nexp = 0; hi = -1;
    for (int i = 0; i < NUM_CHAN; i++) if (mask[i]) begin chan_exp.push_back(i); nexp++; hi = i; end
    exp_q.push_back(mkword(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0));
    exp_q.push_back(mkword(1'b0, !err, err, 1'b0, 1'b0, 32'h0));
    if (err) exp_q.push_back(mkword(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, {12'h000, tm, 12'h000, fm}));
    else for (int i = 0; i < NUM_CHAN; i++)
      if (mask[i]) exp_q.push_back(mkword(1'b0, 1'b0, 1'b0, 1'b1, (i == hi),
                                          32'(delays[i]) | (32'(i) << 8)));
    chan_mask = mask;
    run_sm = 1'b1;
    done = 1'b0;
    for (int k = 0; k < 300 && !done; k++) begin
      step();
      if (sm_done) begin run_sm = 1'b0; done = 1'b1; end
    end
    chk({name, "_bound"}, 40'(done), 40'd1);
    step();
    chk({name, "_idle"}, {38'd0, sm_running, sm_done}, 40'd0);
    chk({name, "_done_cnt"}, 40'(n_done), 40'd1);
    chk({name, "_start_cnt"}, 40'(n_start), 40'(nexp));
    chk({name, "_words_left"}, 40'(exp_q.size()), 40'd0);
    if (mask != 4'b0000)
      chk({name, "_latency"}, 40'(first_valid - last_start), 40'(((nd != 0) ? 15 : l) + 2));
  endtask

  initial begin
    bit seen;
    cyc = 0; cd = 0; lat = 1; never_done = 0; tr_mode = 0; prev_stall = 1'b0; prev_obs = '0;
    fail_vec = 4'b0000;
    delays[0] = 5'd3; delays[1] = 5'd7; delays[2] = 5'd17; delays[3] = 5'd12;
    repeat (2) @(negedge clk);
    chk("reset_ctl", {31'd0, sm_running, sm_done, tx_tvalid, tx_tlast, send_csn, send_cmd,
                      send_inv_cmd, send_data, start_opt}, 40'd0);
    chk("reset_data", {8'd0, tx_data}, 40'd0);
    chk("reset_chan", 40'(opt_chan), 40'd0);
    reset_n = 1'b1;

    run_case("basic", 4'b0101, 3, 0, 0);
    run_case("earliest", 4'b0101, 1, 0, 0);
    run_case("zero_mask", 4'b0000, 2, 0, 0);
    fail_vec = 4'b1000;
    run_case("opt_fail", 4'b1010, 2, 0, 0);
    fail_vec = 4'b0000;
    delays[0] = 5'd5; delays[1] = 5'd9; delays[2] = 5'd31; delays[3] = 5'd0;
    run_case("stall", 4'b1111, 2, 1, 0);
`ifdef CC_OPT_TIMEOUT_EN
    run_case("timeout", 4'b0001, 0, 0, 1);
`endif

    // abort at START_OPT: start_opt must drop combinationally
    never_done = 1; tr_mode = 0; cd = 0; chan_exp.delete(); chan_exp.push_back(0);
    chan_mask = 4'b0001; run_sm = 1'b1; seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin step(); if (start_opt) seen = 1'b1; end
    chk("abort1_seen", 40'(seen), 40'd1);
    run_sm = 1'b0;
    #1;
    chk("abort1_start", 40'(start_opt), 40'd0);
    step();
    chk("abort1_idle", 40'(sm_running), 40'd0);

    // abort during WAIT_OPT
    chan_exp.push_back(0); run_sm = 1'b1; seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin step(); if (start_opt) seen = 1'b1; end
    step();
    chk("abort2_wait", {38'd0, sm_running, start_opt}, 40'd2);
    run_sm = 1'b0;
    step();
    chk("abort2_idle", {36'd0, sm_running, start_opt, tx_tvalid, sm_done}, 40'd0);

    // reset mid-frame with the sink stalled
    delays[0] = 5'd3; delays[2] = 5'd17; never_done = 0; lat = 1; tr_mode = 2; cd = 0;
    chan_exp.delete(); chan_exp.push_back(0); chan_exp.push_back(2);
    chan_mask = 4'b0101; run_sm = 1'b1; seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin step(); if (tx_tvalid) seen = 1'b1; end
    chk("rst_frame_seen", 40'(seen), 40'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_async", {35'd0, sm_running, tx_tvalid, send_csn, start_opt, sm_done}, 40'd0);
    @(negedge clk);
    reset_n = 1'b1; run_sm = 1'b0; prev_stall = 1'b0; cd = 0; tr_mode = 0;
    chk("rst_held", {38'd0, sm_running, tx_tvalid}, 40'd0);
    run_case("after_rst", 4'b0101, 3, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cc_opt_delay_multi_sm.md
# cc_opt_delay_multi_sm

Multi-channel command handler for CC_OPT_DELAY (5'd10). It runs the ADC data-tap-delay optimizer on every channel selected in a mask, one channel at a time, and enforces a per-channel timeout. It then streams the response packet to the TX FIFO: CSN, CC, then one result word per channel. It sits under the command dispatcher, alongside the other cc_*_sm handlers, and shares the CSN/CC/inverse-CC output mux with them.

## Interface
- NUM_CHAN, 4, number of optimizable channels (1..16)
- DELAY_W, 5, width of a tap delay value (1..8)
- DATA_W, 32, TX data width (>= 32)
- TIMEOUT_W, 16, width of the per-channel timeout counter

- clk  in  1  local clock
- reset_n  in  1  asynchronous, active-low reset
- run_sm  in  1  dispatcher enable; low forces IDLE on the next clock edge
- chan_mask  in  NUM_CHAN  channels to optimize; sampled on leaving IDLE
- sm_running  out  1  high in every state except IDLE
- sm_done  out  1  one-cycle pulse in DONE
- tx_tvalid  out  1  word on the mux is valid
- tx_tlast  out  1  final word of the frame
- tx_tready  in  1  TX FIFO accepts the word
- send_csn / send_cmd / send_inv_cmd  out  1 each  select the shared mux source
- send_data  out  1  mux source is tx_data
- tx_data  out  DATA_W  payload word
- opt_chan  out  $clog2(NUM_CHAN) (min 1)  channel under optimization
- start_opt  out  1  one-cycle start pulse to the optimizer
- opt_done  in  1  optimizer finished the current channel
- opt_fail  in  1  optimizer failure, qualified by opt_done
- opt_delay  in  DELAY_W  optimized delay, qualified by opt_done

## Operation
- States: IDLE, LATCH, START_OPT, WAIT_OPT, NEXT_CHAN, ECHO_CSN, ECHO_CC, XMIT_DATA, DONE.
- **IDLE**
  - Moves to LATCH when run_sm is high.
  - Clears fail_mask, tmo_mask and the result registers.
- **LATCH**
  - Registers chan_mask.
  - Zero mask: set err and go to ECHO_CSN.
  - Otherwise load the lowest set bit into opt_chan and go to START_OPT.
- **START_OPT**
  - start_opt = 1 for exactly one cycle.
  - Clear the timeout counter; go to WAIT_OPT.
- **WAIT_OPT**
  - When opt_done is high: store opt_delay in result[opt_chan], and set fail_mask[opt_chan] if opt_fail is high.
  - Otherwise, when the counter reaches its terminal count: set fail_mask and tmo_mask for opt_chan.
  - Either event goes to NEXT_CHAN.
- **NEXT_CHAN**
  - Next higher set mask bit → opt_chan, go to START_OPT.
  - No more set bits → go to ECHO_CSN.
  - err = zero mask OR |fail_mask.
- **ECHO_CSN**: send_csn = 1; tx_tvalid = 1.
- **ECHO_CC**: send_cmd = !err, send_inv_cmd = err; tx_tvalid = 1.
- **XMIT_DATA**: send_data = 1; tx_tvalid = 1.
  - No error: one word per enabled channel, in ascending channel order.
    - tx_data[DELAY_W-1:0] = delay; [15:8] = channel index; all other bits 0.
    - tx_tlast is high on the highest enabled channel.
  - Error: a single word with tx_tlast high.
    - tx_data[NUM_CHAN-1:0] = fail_mask; [16+NUM_CHAN-1:16] = tmo_mask; all other bits 0.
- **DONE**: sm_done = 1; go to IDLE.

## Timing
- Reset (asynchronous, active-low): state = IDLE, all outputs 0, all masks and results 0.
- Handshake is AXI-stream:
  - tx_tvalid is held until a cycle with tvalid & tready.
  - tx_data, tlast and the mux selects are stable while tvalid is high.
  - No combinational path from tready to tvalid.
- A word advances one cycle after its handshake. With tready held high the frame is 2 + words cycles long.
- opt_done is sampled only in WAIT_OPT, so the earliest completion is 1 cycle after start_opt.
- Latency per channel: 2 cycles + optimizer time + 1 cycle.
- Timeout terminal count is 2^TIMEOUT_W − 1 cycles in WAIT_OPT. If opt_done and the terminal count coincide, opt_done wins.
- run_sm low in any state: IDLE on the next edge; start_opt and tvalid drop immediately. A partially sent frame is the dispatcher's responsibility.
- After DONE the block returns to IDLE. If run_sm is still high it starts a new run, so the dispatcher drops run_sm on sm_done.

## Configuration
- CC_OPT_TIMEOUT_EN defined: timeout counter present, behaving as described above.
- Undefined:
  - No counter; WAIT_OPT waits indefinitely for opt_done.
  - tmo_mask stays 0, so the error word's [31:16] is always 0.

## Structure
- Package cc_opt_pkg holds:
  - the CC_OPT_DELAY code;
  - state index constants;
  - result-word field offsets (channel field at 8, timeout field at 16).
- One sub-module: cc_opt_timeout_ctr, which provides clear, enable and a terminal-count flag; it is compiled only under CC_OPT_TIMEOUT_EN.
- Finding the next set mask bit is a combinational priority function in the main module.

## Test plan
- NUM_CHAN=4, mask 4'b0101, optimizer returns delays 3 and 17 with opt_fail=0, tready=1 → words CSN, CC=10, 0x00000003, 0x00000211 (tlast); sm_done pulses once.
- mask 4'b0000 → CSN, ~CC, 0x00000000 (tlast); start_opt never asserts.
- mask 4'b1010, channel 3 returns opt_fail=1 → CSN, ~CC, 0x00000008 (tlast).
- CC_OPT_TIMEOUT_EN with TIMEOUT_W=4, mask 4'b0001, opt_done never asserts → channel 0 times out after 15 cycles in WAIT_OPT; response CSN, ~CC, 0x00010001.
- tready toggled 1-0-0-1 during the frame → tvalid and tx_data hold steady through the stalls; no word is dropped or duplicated.
- run_sm dropped during WAIT_OPT, then reset_n pulsed mid-frame → IDLE on the next edge and the outputs are 0; in the reset case they are 0 immediately and asynchronously.
